lp_filter_sched: RTL and testbench
==================================

# lp_filter_sched

Time-multiplexed multi-channel lowpass filter engine. One shared subtract/shift/add datapath serves CHANNELS independent sensor channels, each with STAGE_COUNT cascaded first-order stages. A round-robin scheduler picks a channel with a pending sample and runs its stages one per cycle. Per-channel state lives in a register bank. The block sits between the per-channel period/frequency measurement units and the downstream consumer, replacing one filter instance per channel.

## Interface
- CHANNELS, 4: number of channels, 2..16.
- IN_DATA_BITS, 28: input sample width, unsigned.
- OUT_DATA_BITS, 28: output width, ≥ IN_DATA_BITS.
- SHIFT_BITS, 5: per-stage shift.
- STAGE_COUNT, 2: stages per channel, 1..5.

- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CE  in  1  clock enable for scheduler and datapath.
- IN_VALUE  in  CHANNELS*IN_DATA_BITS  channel c is bits [c*IN_DATA_BITS +: IN_DATA_BITS].
- IN_VALID  in  CHANNELS  one-cycle strobe per channel.
- OUT_VALUE  out  OUT_DATA_BITS  filtered value of OUT_CHANNEL.
- OUT_CHANNEL  out  clog2(CHANNELS)  channel index of OUT_VALUE.
- OUT_VALID  out  1  one-cycle strobe.
- BUSY  out  1  FSM not in IDLE.
- OVERRUN  out  CHANNELS  sticky per-channel overrun flags.

## Operation
- Capture ignores CE. IN_VALID[c] writes the hold register for channel c and sets pending[c]. If pending[c] is already set, OVERRUN[c] is also set and the newer sample wins.
- Internal state width is W = OUT_DATA_BITS + SHIFT_BITS. The input is zero-padded on the right to OUT_DATA_BITS, then shifted left by SHIFT_BITS to form x.
- Stage k update: s_k ← s_k + ((x_k − s_k) >>> SHIFT_BITS).
  - The difference is signed, W+1 bits; the result is truncated to W bits.
  - x_0 is the padded input. x_k is the freshly updated s_{k−1}.
- OUT_VALUE is s_last[W−1 : SHIFT_BITS].
- FSM states:
  - IDLE: if CE and any pending bit is set, grant the first pending channel after last_served (wrapping), copy its hold register to the work register, clear pending, set stage counter to 0, go to RUN.
  - RUN: on each CE cycle, update one stage of the granted channel. After stage STAGE_COUNT−1, go to OUT.
  - OUT: OUT_VALID=1 for one CE cycle, update last_served, go to IDLE.
- Simultaneous events:
  - IN_VALID for the channel granted in the same cycle writes the hold register and leaves pending set. This is not an overrun; the new sample is processed in a later pass.
  - IN_VALID for a non-granted pending channel counts as an overrun.
- CE=0 freezes the FSM, stage counter, state bank and outputs. OUT_VALID is gated by CE (OUT_VALID = state==OUT & CE).
- Reset values: state bank, hold registers, pending, OVERRUN, OUT_VALUE, OUT_CHANNEL are 0; OUT_VALID=0, BUSY=0; FSM=IDLE; last_served=CHANNELS−1, so channel 0 has first priority. Reset mid-pass discards the pass with no output.

## Timing
- IN_VALID in cycle t → pending in t+1 → grant in t+1 if IDLE → stages in t+2..t+STAGE_COUNT+1 → OUT_VALID in t+STAGE_COUNT+2 (all CE=1).
- Per-update period is STAGE_COUNT+2 cycles. Sustained per-channel sample rate must be ≤ 1/(CHANNELS*(STAGE_COUNT+2)) to avoid overrun.
- OUT_VALUE and OUT_CHANNEL hold their values until the next OUT_VALID.

## Configuration
- LP_FILTER_SCHED_PRELOAD_EN defined: a per-channel "primed" flag, cleared by reset. The first pass of an unprimed channel loads every stage with x directly, so output = padded input. The pass then sets primed.
- Macro undefined: every stage starts from 0 and ramps up; there is no primed flag.

## Structure
- Package lp_filter_pkg holds:
  - FSM state enum (IDLE, RUN, OUT);
  - state width W and channel-index width constants;
  - the sample padding function.
- Sub-module lp_filter_rr_arbiter: pending vector plus last_served in, one-hot grant and index out, combinational.
- The state bank is a CHANNELS×STAGE_COUNT×W register array, addressed by channel and stage counter.

## Test plan
- Step response: SHIFT_BITS=5, IN=OUT=28, STAGE_COUNT=2, channel 0 receives 0x0000400 from reset → OUT_VALID at t+4, OUT_CHANNEL=0, OUT_VALUE=0x0000001. With PRELOAD_EN the value is 0x0000400.
- Fairness: IN_VALID=4'b1111 in one cycle → OUT_VALID at t+4, t+8, t+12, t+16 with channels 0,1,2,3. No OVERRUN.
- Overrun: channel 1 receives 0x10 then 0x20 while channel 0 is in its pass → OVERRUN=4'b0010 and the channel 1 pass uses 0x20. OVERRUN stays set until RESET.
- Grant collision: IN_VALID[2] in channel 2's grant cycle → two consecutive channel 2 outputs and OVERRUN[2]=0.
- CE hold: CE=0 for 5 cycles mid-RUN → output delayed exactly 5 cycles with the same value. A capture during the stall is still registered.
- Reset mid-pass: RESET during RUN → no OUT_VALID. Next step test from 0 reproduces the first scenario.

Source files
------------

// File: rtl/lp_filter_pkg.sv
// ============================================================================
// lp_filter_pkg : shared types, width helpers and sample padding for the
//                 time-multiplexed lowpass filter engine.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package lp_filter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } fsm_state_t;

  // Padding is evaluated at this fixed width, so the state width must not exceed it.
  localparam int PAD_MAX_BITS = 64;

  function automatic int state_width(input int out_bits, input int shift_bits);
    return out_bits + shift_bits;
  endfunction

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [PAD_MAX_BITS-1:0] pad_sample(
    input logic [PAD_MAX_BITS-1:0] value,
    input int                      in_bits,
    input int                      out_bits,
    input int                      shift_bits
  );
    return value << (out_bits - in_bits + shift_bits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lp_filter_rr_arbiter.sv
// ============================================================================
// lp_filter_rr_arbiter : combinational round-robin pick of the first pending
//                        channel after the last one served.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module lp_filter_rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [CHANNELS-1:0] i_pending,
  input  logic [IDX_BITS-1:0] i_last,
  output logic [CHANNELS-1:0] o_grant,
  output logic [IDX_BITS-1:0] o_index,
  output logic                o_valid
);

  logic [IDX_BITS-1:0] w_cand;

  // Walk farthest-first so the nearest pending channel after i_last wins.
  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      w_cand = IDX_BITS'((int'(i_last) + i) % CHANNELS);
      if (i_pending[w_cand]) begin
        o_index = w_cand;
        o_valid = 1'b1;
      end
    end
    if (o_valid) o_grant[o_index] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/lp_filter_sched.sv
// ============================================================================
// lp_filter_sched : shared-datapath multi-channel cascaded first-order
//                   lowpass filter. Optional macro LP_FILTER_SCHED_PRELOAD_EN
//                   loads a channel's first sample straight into its stages.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module lp_filter_sched
  import lp_filter_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int IN_DATA_BITS  = 28,
  parameter int OUT_DATA_BITS = 28,
  parameter int SHIFT_BITS    = 5,
  parameter int STAGE_COUNT   = 2
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                CE,
  input  logic [CHANNELS*IN_DATA_BITS-1:0]    IN_VALUE,
  input  logic [CHANNELS-1:0]                 IN_VALID,
  output logic [OUT_DATA_BITS-1:0]            OUT_VALUE,
  output logic [index_width(CHANNELS)-1:0]    OUT_CHANNEL,
  output logic                                OUT_VALID,
  output logic                                BUSY,
  output logic [CHANNELS-1:0]                 OVERRUN
);

  localparam int W  = state_width(OUT_DATA_BITS, SHIFT_BITS);
  localparam int CW = index_width(CHANNELS);
  localparam int SW = index_width(STAGE_COUNT);
  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGE_COUNT - 1);

  fsm_state_t               r_state, w_state_nxt;
  logic [IN_DATA_BITS-1:0]  r_hold [CHANNELS];
  logic [CHANNELS-1:0]      r_pending;
  logic [CHANNELS-1:0]      r_overrun;
  logic [W-1:0]             r_bank [CHANNELS][STAGE_COUNT];
  logic [W-1:0]             r_x;
  logic [CW-1:0]            r_ch;
  logic [CW-1:0]            r_last;
  logic [SW-1:0]            r_stage;
  logic [OUT_DATA_BITS-1:0] r_out_value;
  logic [CW-1:0]            r_out_ch;

  logic [CHANNELS-1:0]      w_grant;
  logic [CW-1:0]            w_grant_idx;
  logic                     w_grant_any;
  logic                     w_grant_fire;
  logic                     w_stage_fire;
  logic                     w_out_fire;
  logic                     w_load;
  logic [W-1:0]             w_x_pad;
  logic [W-1:0]             w_s_cur;
  logic [W-1:0]             w_s_upd;
  logic [W-1:0]             w_s_new;
  logic signed [W:0]        w_diff;
  logic signed [W:0]        w_step;

  lp_filter_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .IDX_BITS (CW)
  ) u_arb (
    .i_pending (r_pending),
    .i_last    (r_last),
    .o_grant   (w_grant),
    .o_index   (w_grant_idx),
    .o_valid   (w_grant_any)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_fire = 1'b0;
    w_stage_fire = 1'b0;
    w_out_fire   = 1'b0;
    case (r_state)
      IDLE: if (CE && w_grant_any) begin
        w_grant_fire = 1'b1;
        w_state_nxt  = RUN;
      end
      RUN: if (CE) begin
        w_stage_fire = 1'b1;
        if (r_stage == LAST_STAGE) w_state_nxt = OUT;
      end
      OUT: if (CE) begin
        w_out_fire  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture runs regardless of CE; a sample landing on its own grant cycle stays pending.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pending <= '0;
      r_overrun <= '0;
      for (int c = 0; c < CHANNELS; c++) r_hold[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (IN_VALID[c]) begin
          r_hold[c]    <= IN_VALUE[c*IN_DATA_BITS +: IN_DATA_BITS];
          r_pending[c] <= 1'b1;
          if (r_pending[c] && !(w_grant_fire && w_grant[c])) r_overrun[c] <= 1'b1;
        end else if (w_grant_fire && w_grant[c]) begin
          r_pending[c] <= 1'b0;
        end
      end
    end
  end

  assign w_x_pad = W'(pad_sample(PAD_MAX_BITS'(r_hold[w_grant_idx]),
                                 IN_DATA_BITS, OUT_DATA_BITS, SHIFT_BITS));
  assign w_s_cur = r_bank[r_ch][r_stage];
  assign w_diff  = $signed({1'b0, r_x}) - $signed({1'b0, w_s_cur});
  assign w_step  = w_diff >>> SHIFT_BITS;
  assign w_s_upd = W'($signed({1'b0, w_s_cur}) + w_step);
  assign w_s_new = w_load ? r_x : w_s_upd;

`ifdef LP_FILTER_SCHED_PRELOAD_EN
  logic [CHANNELS-1:0] r_primed;
  assign w_load = ~r_primed[r_ch];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)           r_primed       <= '0;
    else if (w_out_fire) r_primed[r_ch] <= 1'b1;
  end
`else
  assign w_load = 1'b0;
`endif

  // r_x carries the stage input: padded sample first, then each fresh stage result.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_x         <= '0;
      r_ch        <= '0;
      r_stage     <= '0;
      r_last      <= CW'(CHANNELS - 1);
      r_out_value <= '0;
      r_out_ch    <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int s = 0; s < STAGE_COUNT; s++)
          r_bank[c][s] <= '0;
    end else begin
      if (w_grant_fire) begin
        r_x     <= w_x_pad;
        r_ch    <= w_grant_idx;
        r_stage <= '0;
      end
      if (w_stage_fire) begin
        r_bank[r_ch][r_stage] <= w_s_new;
        r_x                   <= w_s_new;
        r_stage               <= r_stage + 1'b1;
        if (r_stage == LAST_STAGE) begin
          r_out_value <= w_s_new[W-1:SHIFT_BITS];
          r_out_ch    <= r_ch;
        end
      end
      if (w_out_fire) r_last <= r_ch;
    end
  end

  assign OUT_VALUE   = r_out_value;
  assign OUT_CHANNEL = r_out_ch;
  assign OUT_VALID   = w_out_fire;
  assign BUSY        = (r_state != IDLE);
  assign OVERRUN     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_lp_filter_sched.sv
// ============================================================================
// tb_lp_filter_sched : directed self-checking bench for lp_filter_sched
//                      (default build, preload macro undefined).
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_lp_filter_sched;

  logic         CLK;
  logic         RESET;
  logic         CE;
  logic [111:0] IN_VALUE;
  logic [3:0]   IN_VALID;
  logic [27:0]  OUT_VALUE;
  logic [1:0]   OUT_CHANNEL;
  logic         OUT_VALID;
  logic         BUSY;
  logic [3:0]   OVERRUN;

  int n_cmp = 0;
  int n_err = 0;

  lp_filter_sched #(
    .CHANNELS      (4),
    .IN_DATA_BITS  (28),
    .OUT_DATA_BITS (28),
    .SHIFT_BITS    (5),
    .STAGE_COUNT   (2)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .CE          (CE),
    .IN_VALUE    (IN_VALUE),
    .IN_VALID    (IN_VALID),
    .OUT_VALUE   (OUT_VALUE),
    .OUT_CHANNEL (OUT_CHANNEL),
    .OUT_VALID   (OUT_VALID),
    .BUSY        (BUSY),
    .OVERRUN     (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; CE = 1'b1; IN_VALID = '0; IN_VALUE = '0;
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1; CE = 1'b1; IN_VALID = '0; IN_VALUE = '0;
    tick();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", OUT_VALID); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (OVERRUN !== 4'b0000) begin n_err++; $display("FAIL reset_overrun: got %b want 0000", OVERRUN); end
    n_cmp++; if (OUT_VALUE !== 28'h0) begin n_err++; $display("FAIL reset_value: got %h want 0", OUT_VALUE); end
    n_cmp++; if (OUT_CHANNEL !== 2'd0) begin n_err++; $display("FAIL reset_channel: got %0d want 0", OUT_CHANNEL); end
    RESET = 1'b0;
    tick();
  endtask

  // Channel-0 single pass; sample driven in the current cycle t.
  task automatic test_step(input logic [27:0] v, input logic [27:0] exp_val);
    IN_VALUE = '0; IN_VALUE[27:0] = v; IN_VALID = 4'b0001;
    tick(); IN_VALID = '0;
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL step_busy_t1: got %b want 0", BUSY); end
    tick();
    n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL step_busy_t2: got %b want 1", BUSY); end
    tick();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL step_early_valid: got %b want 0", OUT_VALID); end
    tick();
    n_cmp++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL step_valid: got %b want 1", OUT_VALID); end
    n_cmp++; if (OUT_CHANNEL !== 2'd0) begin n_err++; $display("FAIL step_channel: got %0d want 0", OUT_CHANNEL); end
    n_cmp++; if (OUT_VALUE !== exp_val) begin n_err++; $display("FAIL step_value: got %h want %h", OUT_VALUE, exp_val); end
    tick();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL step_valid_drop: got %b want 0", OUT_VALID); end
    n_cmp++; if (OUT_VALUE !== exp_val) begin n_err++; $display("FAIL step_value_hold: got %h want %h", OUT_VALUE, exp_val); end
  endtask

  // Ramp with a falling input exercises the negative (arithmetic) shift.
  task automatic test_decay();
    test_step(28'h0100000, 28'h0000400);
    test_step(28'h0000000, 28'h00007C0);
    test_step(28'h0000000, 28'h0000B43);
  endtask

  task automatic test_fairness();
    IN_VALUE = {28'h0001000, 28'h0000C00, 28'h0000800, 28'h0000400};
    IN_VALID = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick(); IN_VALID = '0;
      tick();
      tick();
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL fair_gap%0d: got %b want 0", k, OUT_VALID); end
      tick();
      n_cmp++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL fair_valid%0d: got %b want 1", k, OUT_VALID); end
      n_cmp++; if (OUT_CHANNEL !== 2'(k)) begin n_err++; $display("FAIL fair_channel%0d: got %0d want %0d", k, OUT_CHANNEL, k); end
      n_cmp++; if (OUT_VALUE !== 28'(k + 1)) begin n_err++; $display("FAIL fair_value%0d: got %h want %h", k, OUT_VALUE, k + 1); end
    end
    n_cmp++; if (OVERRUN !== 4'b0000) begin n_err++; $display("FAIL fair_overrun: got %b want 0000", OVERRUN); end
  endtask

  task automatic test_overrun();
    IN_VALUE = '0; IN_VALUE[27:0] = 28'h0000400; IN_VALID = 4'b0001;
    tick(); IN_VALID = '0;
    tick();
    IN_VALUE[55:28] = 28'h0010000; IN_VALID = 4'b0010;
    tick();
    n_cmp++; if (OVERRUN !== 4'b0000) begin n_err++; $display("FAIL ovr_first_capture: got %b want 0000", OVERRUN); end
    IN_VALUE[55:28] = 28'h0020000; IN_VALID = 4'b0010;
    tick(); IN_VALID = '0;
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_CHANNEL !== 2'd0) begin n_err++; $display("FAIL ovr_ch0_out: got valid %b ch %0d want 1 ch 0", OUT_VALID, OUT_CHANNEL); end
    n_cmp++; if (OVERRUN !== 4'b0010) begin n_err++; $display("FAIL ovr_flag: got %b want 0010", OVERRUN); end
    tick(); tick(); tick(); tick();
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_CHANNEL !== 2'd1) begin n_err++; $display("FAIL ovr_ch1_out: got valid %b ch %0d want 1 ch 1", OUT_VALID, OUT_CHANNEL); end
    n_cmp++; if (OUT_VALUE !== 28'h0000080) begin n_err++; $display("FAIL ovr_newer_wins: got %h want 0000080", OUT_VALUE); end
    tick(); tick(); tick();
    n_cmp++; if (OVERRUN !== 4'b0010) begin n_err++; $display("FAIL ovr_sticky: got %b want 0010", OVERRUN); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL ovr_idle: got %b want 0", BUSY); end
  endtask

  task automatic test_grant_collision();
    IN_VALUE = '0; IN_VALUE[83:56] = 28'h0000800; IN_VALID = 4'b0100;
    tick();
    IN_VALUE[83:56] = 28'h0001000; IN_VALID = 4'b0100;
    tick(); IN_VALID = '0;
    tick(); tick();
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_CHANNEL !== 2'd2) begin n_err++; $display("FAIL coll_first_out: got valid %b ch %0d want 1 ch 2", OUT_VALID, OUT_CHANNEL); end
    n_cmp++; if (OUT_VALUE !== 28'h0000002) begin n_err++; $display("FAIL coll_first_value: got %h want 0000002", OUT_VALUE); end
    tick(); tick(); tick(); tick();
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_CHANNEL !== 2'd2) begin n_err++; $display("FAIL coll_second_out: got valid %b ch %0d want 1 ch 2", OUT_VALID, OUT_CHANNEL); end
    n_cmp++; if (OUT_VALUE !== 28'h0000007) begin n_err++; $display("FAIL coll_second_value: got %h want 0000007", OUT_VALUE); end
    n_cmp++; if (OVERRUN !== 4'b0000) begin n_err++; $display("FAIL coll_overrun: got %b want 0000", OVERRUN); end
  endtask

  task automatic test_ce_hold();
    logic saw_valid;
    saw_valid = 1'b0;
    IN_VALUE = '0; IN_VALUE[27:0] = 28'h0000400; IN_VALID = 4'b0001;
    tick(); IN_VALID = '0;
    tick();
    tick(); CE = 1'b0;
    n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL ce_busy: got %b want 1", BUSY); end
    tick();
    IN_VALUE[111:84] = 28'h0000400; IN_VALID = 4'b1000;
    if (OUT_VALID !== 1'b0) saw_valid = 1'b1;
    tick(); IN_VALID = '0;
    for (int i = 0; i < 3; i++) begin
      if (OUT_VALID !== 1'b0) saw_valid = 1'b1;
      tick();
    end
    CE = 1'b1;
    n_cmp++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL ce_stall_valid: got %b want 0", saw_valid); end
    tick();
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_CHANNEL !== 2'd0) begin n_err++; $display("FAIL ce_delayed_out: got valid %b ch %0d want 1 ch 0", OUT_VALID, OUT_CHANNEL); end
    n_cmp++; if (OUT_VALUE !== 28'h0000001) begin n_err++; $display("FAIL ce_value: got %h want 0000001", OUT_VALUE); end
    tick(); tick(); tick(); tick();
    CE = 1'b0; #1;
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL ce_gate_out: got %b want 0", OUT_VALID); end
    CE = 1'b1; #1;
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_CHANNEL !== 2'd3) begin n_err++; $display("FAIL ce_stall_capture: got valid %b ch %0d want 1 ch 3", OUT_VALID, OUT_CHANNEL); end
    n_cmp++; if (OUT_VALUE !== 28'h0000001) begin n_err++; $display("FAIL ce_ch3_value: got %h want 0000001", OUT_VALUE); end
    n_cmp++; if (OVERRUN !== 4'b0000) begin n_err++; $display("FAIL ce_overrun: got %b want 0000", OVERRUN); end
    tick();
  endtask

  task automatic test_reset_mid_pass();
    logic saw_valid;
    saw_valid = 1'b0;
    IN_VALUE = '0; IN_VALUE[27:0] = 28'h0000400; IN_VALID = 4'b0001;
    tick(); IN_VALID = '0;
    tick();
    RESET = 1'b1; #1;
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", BUSY); end
    tick(); RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (OUT_VALID !== 1'b0) saw_valid = 1'b1;
      tick();
    end
    n_cmp++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_out: got %b want 0", saw_valid); end
    test_step(28'h0000400, 28'h0000001);
  endtask

  task automatic test_boundary();
    IN_VALUE = '0; IN_VALUE[111:84] = 28'hFFFFFFF; IN_VALID = 4'b1000;
    tick(); IN_VALID = '0;
    tick(); tick(); tick();
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_CHANNEL !== 2'd3) begin n_err++; $display("FAIL max_out: got valid %b ch %0d want 1 ch 3", OUT_VALID, OUT_CHANNEL); end
    n_cmp++; if (OUT_VALUE !== 28'h003FFFF) begin n_err++; $display("FAIL max_value: got %h want 003FFFF", OUT_VALUE); end
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b1; IN_VALID = '0; IN_VALUE = '0;
    test_reset();
    test_step(28'h0000400, 28'h0000001);
    do_reset(); test_decay();
    do_reset(); test_fairness();
    do_reset(); test_overrun();
    do_reset(); test_grant_collision();
    do_reset(); test_ce_hold();
    do_reset(); test_reset_mid_pass();
    do_reset(); test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
